// File: rtl/uart_rx_port_if.sv
// KCPSM6 read-port and interrupt signals between the processor and the UART receive port.
interface uart_rx_port_if;
  logic [7:0] port_id;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  modport master (
    output port_id, read_strobe, interrupt_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, read_strobe, interrupt_ack,
    output in_port, interrupt
  );
endinterface

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver with 16x oversampling, a small byte FIFO and a KCPSM6 read port.
module uart_rx_port #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter int unsigned FIFO_AW     = 4,
  parameter logic [7:0]  PORT_DATA   = 8'h0A,
  parameter logic [7:0]  PORT_STATUS = 8'h0B
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          uart_rx,
  uart_rx_port_if.slave bus
);

  localparam int unsigned DIV   = CLK_HZ / (BAUD * 16);
  localparam int unsigned DivW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned Depth = 1 << FIFO_AW;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e             state_q, state_d;
  logic [1:0]         sync_q;
  logic               rxs;
  logic [DivW-1:0]    div_q, div_d;
  logic               tick;
  logic [3:0]         tcnt_q, tcnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               push_req, ferr_set;

  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               empty, full, pop, push, ovr_set, stat_clr;
  logic               ovr_q, ovr_d, ferr_q, ferr_d, irq_q, irq_d;
  logic [7:0]         in_port_q, in_port_d;

  assign rxs  = sync_q[1];
  assign tick = (div_q == DivW'(DIV - 1));

  always_comb begin
    state_d  = state_q;
    div_d    = tick ? '0 : div_q + DivW'(1);
    tcnt_d   = tcnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Holding the divider at zero aligns ticks to the detected start edge.
        div_d = '0;
        if (!rxs) begin
          state_d = StStart;
          tcnt_d  = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (tcnt_q == 4'd7) begin
            tcnt_d = '0;
            bit_d  = '0;
            state_d = rxs ? StIdle : StData;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            shift_d[bit_q] = rxs;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = StStop;
          end
        end
      end
      StStop: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            if (rxs) begin
              push_req = 1'b1;
              state_d  = StIdle;
            end else begin
              ferr_set = 1'b1;
              state_d  = StBreak;
            end
          end
        end
      end
      StBreak: begin
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign empty    = (count_q == '0);
  assign full     = count_q[FIFO_AW];
  assign pop      = bus.read_strobe && (bus.port_id == PORT_DATA) && !empty;
  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  assign push     = push_req && (!full || pop);
  assign ovr_set  = push_req && full && !pop;
  assign stat_clr = bus.read_strobe && (bus.port_id == PORT_STATUS);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovr_d  = ovr_set  ? 1'b1 : (stat_clr ? 1'b0 : ovr_q);
    ferr_d = ferr_set ? 1'b1 : (stat_clr ? 1'b0 : ferr_q);
    irq_d  = (push && empty) ? 1'b1 : (bus.interrupt_ack ? 1'b0 : irq_q);
    in_port_d = 8'h00;
    if (bus.port_id == PORT_DATA) begin
      in_port_d = empty ? 8'h00 : mem_q[rd_ptr_q];
    end else if (bus.port_id == PORT_STATUS) begin
      in_port_d = {4'b0000, ovr_q, ferr_q, full, ~empty};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      sync_q    <= 2'b11;
      div_q     <= '0;
      tcnt_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      irq_q     <= 1'b0;
      in_port_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], uart_rx};
      div_q     <= div_d;
      tcnt_q    <= tcnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      irq_q     <= irq_d;
      in_port_q <= in_port_d;
    end
  end

  assign bus.in_port   = in_port_q;
  assign bus.interrupt = irq_q;

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port: framing, glitch, overrun, push/pop collision and reset.
module tb_uart_rx_port;

  // Divider of 4 (64 clocks/bit ideal) keeps the run short; 65 clocks/bit adds rate skew.
  localparam int unsigned ClkHz   = 7_372_800;
  localparam int          BitClks = 65;
  localparam logic [7:0]  PortData   = 8'h0A;
  localparam logic [7:0]  PortStatus = 8'h0B;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic uart_rx = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  uart_rx_port_if bus ();

  uart_rx_port #(
    .CLK_HZ      (ClkHz),
    .BAUD        (115_200),
    .FIFO_AW     (4),
    .PORT_DATA   (PortData),
    .PORT_STATUS (PortStatus)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .uart_rx (uart_rx),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int n);
    uart_rx = b;
    step(n);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_val);
    drive_bit(1'b0, BitClks);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BitClks);
    drive_bit(stop_val, BitClks);
    uart_rx = 1'b1;
  endtask

  task automatic rd(input logic [7:0] pid, input logic strobe, output logic [7:0] val);
    bus.port_id     = pid;
    bus.read_strobe = strobe;
    step(1);
    bus.read_strobe = 1'b0;
    val = bus.in_port;
    bus.port_id = 8'h00;
  endtask

  task automatic ack();
    bus.interrupt_ack = 1'b1;
    step(1);
    bus.interrupt_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] pat;
    int s;
    int d_push;

    bus.port_id = 8'h00;
    bus.read_strobe = 1'b0;
    bus.interrupt_ack = 1'b0;
    step(3);
    check_eq("rst_in_port", 32'(bus.in_port), 32'h00);
    check_eq("rst_irq", 32'(bus.interrupt), 32'h0);
    reset = 1'b1;
    step(3);

    // 0xA5, timing how long from start edge to the interrupt
    s = cyc;
    d_push = -1;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 20 * BitClks && d_push < 0; i++) begin
          @(negedge clk);
          if (bus.interrupt) d_push = cyc - s;
        end
      end
    join
    check_eq("irq_latency_in_window", 32'(d_push >= 590 && d_push <= 640), 32'h1);
    if (d_push < 2) d_push = 611;
    check_eq("a5_irq", 32'(bus.interrupt), 32'h1);
    ack();
    check_eq("a5_irq_acked", 32'(bus.interrupt), 32'h0);
    rd(PortStatus, 1'b1, v); check_eq("a5_status", 32'(v), 32'h01);
    rd(PortData, 1'b1, v);   check_eq("a5_data", 32'(v), 32'hA5);
    rd(PortStatus, 1'b1, v); check_eq("a5_status_after", 32'(v), 32'h00);

    // Short low glitch on an idle line
    drive_bit(1'b0, 20);
    drive_bit(1'b1, 4 * BitClks);
    rd(PortStatus, 1'b1, v); check_eq("glitch_status", 32'(v), 32'h00);
    check_eq("glitch_irq", 32'(bus.interrupt), 32'h0);

    // Framing error: stop bit low
    send_byte(8'h3C, 1'b0);
    step(BitClks);
    rd(PortStatus, 1'b1, v); check_eq("ferr_status", 32'(v), 32'h04);
    rd(PortStatus, 1'b1, v); check_eq("ferr_cleared", 32'(v), 32'h00);
    check_eq("ferr_irq", 32'(bus.interrupt), 32'h0);

    // Overrun: 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
    rd(PortStatus, 1'b0, v); check_eq("ovr_status", 32'(v), 32'h0B);
    check_eq("ovr_irq", 32'(bus.interrupt), 32'h1);
    ack();
    for (int i = 0; i < 16; i++) begin
      rd(PortData, 1'b1, v);
      check_eq($sformatf("ovr_order_%0d", i), 32'(v), 32'(i));
    end
    rd(PortData, 1'b1, v);   check_eq("ovr_empty_data", 32'(v), 32'h00);
    rd(PortStatus, 1'b1, v); check_eq("ovr_empty_status", 32'(v), 32'h08);
    rd(PortStatus, 1'b1, v); check_eq("ovr_cleared", 32'(v), 32'h00);

    // Pop in the very cycle the 17th byte lands in a full FIFO
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 1'b1);
    ack();
    s = cyc;
    fork
      send_byte(8'h30, 1'b1);
      begin
        step(d_push - 1);
        bus.port_id = PortData;
        bus.read_strobe = 1'b1;
        step(1);
        bus.read_strobe = 1'b0;
        v = bus.in_port;
        bus.port_id = 8'h00;
      end
    join
    check_eq("coll_head", 32'(v), 32'h20);
    rd(PortStatus, 1'b0, v); check_eq("coll_status", 32'(v), 32'h03);
    for (int i = 1; i < 17; i++) begin
      rd(PortData, 1'b1, v);
      check_eq($sformatf("coll_order_%0d", i), 32'(v), 32'h20 + 32'(i));
    end
    rd(PortStatus, 1'b0, v); check_eq("coll_drained", 32'(v), 32'h00);
    check_eq("coll_irq", 32'(bus.interrupt), 32'h0);

    // Reset in the middle of bit 4
    send_byte(8'h77, 1'b1);
    bus.port_id = PortData;
    step(1);
    check_eq("pre_rst_data", 32'(bus.in_port), 32'h77);
    pat = 8'hC3;
    drive_bit(1'b0, BitClks);
    for (int i = 0; i < 4; i++) drive_bit(pat[i], BitClks);
    drive_bit(pat[4], BitClks / 2);
    reset = 1'b0;
    uart_rx = 1'b1;
    step(2);
    check_eq("mid_rst_in_port", 32'(bus.in_port), 32'h00);
    check_eq("mid_rst_irq", 32'(bus.interrupt), 32'h0);
    step(5);
    reset = 1'b1;
    bus.port_id = 8'h00;
    step(4 * BitClks);
    send_byte(8'h5A, 1'b1);
    check_eq("post_rst_irq", 32'(bus.interrupt), 32'h1);
    rd(PortStatus, 1'b0, v); check_eq("post_rst_status", 32'(v), 32'h01);
    rd(PortData, 1'b1, v);   check_eq("post_rst_data", 32'(v), 32'h5A);
    rd(PortStatus, 1'b0, v); check_eq("post_rst_empty", 32'(v), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_port.md
Name: uart_rx_port

Overview:
- Serial receive side of the host link: deserialises 8N1 bytes arriving on uart_rx from the host PC.
- Buffers received bytes in a small FIFO.
- Presents the bytes and a status register to the KCPSM6 (PicoBlaze) through its port_id/read_strobe/in_port read interface.
- Raises an interrupt when data becomes available.
- Sits beside the bot interface on the 100 MHz system clock as the counterpart of the existing uart_tx path.

Parameters:
- CLK_HZ, 100000000, system clock frequency.
- BAUD, 115200, line rate.
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW = 16.
- PORT_DATA, 8'h0A, port_id that returns and pops the FIFO head.
- PORT_STATUS, 8'h0B, port_id that returns status.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- uart_rx  input  1  asynchronous serial line; idles high.
- port_id  input  8  KCPSM6 port address.
- read_strobe  input  1  KCPSM6 read strobe, one cycle.
- in_port  output  8  registered read data; 0x00 when port_id matches neither port.
- interrupt  output  1  to KCPSM6 interrupt.
- interrupt_ack  input  1  from KCPSM6.

Behaviour:
- Reset (reset=0, async): FSM=IDLE, FIFO empty, pointers=0, in_port=0x00, interrupt=0, frame_err=0, overrun=0, rx synchroniser=11.
- Input sync: uart_rx passes through a 2-flop synchroniser. All decisions use the synchronised value rxs.
- Tick generator:
  - DIV = CLK_HZ/(BAUD*16), integer-truncated; 54 at defaults.
  - The counter produces a 1-cycle tick every DIV clocks.
  - The counter restarts at 0 on the IDLE->START transition.
- FSM (advances only on ticks, except IDLE):
  - IDLE: rxs=0 -> START, tick count cleared.
  - START: after 8 ticks, sample rxs. If 0 -> DATA with bit=0. If 1 -> IDLE (glitch rejected, nothing stored).
  - DATA: every 16 ticks sample rxs into shift[bit], LSB first. After bit 7 -> STOP.
  - STOP: after 16 ticks sample rxs.
    - 1: push byte to FIFO -> IDLE.
    - 0: discard byte, set frame_err sticky -> BREAK.
  - BREAK: wait for rxs=1 (any cycle) -> IDLE.
- Push rules:
  - Push while full: byte dropped, overrun set sticky, FIFO contents unchanged.
  - The push is visible to a status read 1 cycle after the STOP sample.
- Read interface:
  - in_port is registered every cycle from the current port_id.
  - DATA -> FIFO head (0x00 if empty).
  - STATUS -> {4'b0, overrun, frame_err, full, ~empty}.
  - Any other port_id -> 0x00.
  - KCPSM6 samples in_port 2 cycles after port_id is driven, so 1-cycle registration meets timing.
- Pop: read_strobe=1 with port_id=PORT_DATA and FIFO not empty pops one entry. A read while empty does nothing.
- Status clear: read_strobe=1 with port_id=PORT_STATUS clears overrun and frame_err after the value is returned. If a set and a clear land in the same cycle, the set wins.
- Simultaneous push and pop: both performed, count unchanged. A push and pop together when full succeeds (no overrun). When empty, a pop does nothing and the push proceeds.
- Count width is FIFO_AW+1; pointers wrap modulo 2^FIFO_AW.
- Interrupt:
  - Set on the cycle a push lands in an empty FIFO.
  - Held until interrupt_ack=1, then cleared.
  - If a push into empty and an ack occur together, interrupt remains 1.
- Reset mid-frame: immediate return to IDLE. The partial byte is lost and the FIFO is emptied.

Test Plan:
- Defaults; send 0xA5 as 8N1 at 868 clocks/bit (54*16=864 ideal; ±1% tolerated) -> interrupt rises ~1 cycle after stop sample. STATUS read=0x01. DATA read=0xA5. Next STATUS=0x00.
- 300-clock low pulse on an idle line -> START rejects; FIFO stays empty, STATUS=0x00, no interrupt.
- Send 0x3C with stop bit driven 0, then line high -> STATUS=0x04, no push. After STATUS read, next STATUS=0x00.
- Send 17 bytes 0x00..0x10 with no reads -> STATUS=0x0B (overrun, full, nonempty). Reads return 0x00..0x0F in order, then empty (0x00, STATUS=0x08 until cleared).
- Pulse read_strobe on PORT_DATA in the exact cycle a byte is pushed with FIFO holding 16 entries -> no overrun; count stays 16; oldest byte returned.
- Assert reset=0 during bit 4 of a frame, release, send 0x5A -> only 0x5A in FIFO; all outputs were 0 during reset.
